contador_mod_6: RTL and testbench



---
 rtl/contador_mod_6.sv | 37 +++
 tb/tb_contador_mod_6.sv | 125 ++++++++++++
 2 files changed

// File: rtl/contador_mod_6.sv
// Modulo-6 down-counter for the tens digit of a min:sec timer.
// Counts 5..0 and wraps to 5. It also supports clear, saturating parallel load, and a borrow output for cascading.
module contador_mod_6 (
    input  logic       clk,
    input  logic       clearn,
    input  logic [2:0] data,
    input  logic       loadn,
    input  logic       en,
    output logic [2:0] tens,
    output logic       tc,
    output logic       zero
);

    localparam logic [2:0] MAX_DIGIT = 3'd5;

    logic [2:0] load_value;

    // Out-of-range load values clamp to 5, so the register can never hold 6 or 7.
    always_comb begin
        load_value = (data > MAX_DIGIT) ? MAX_DIGIT : data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clearn) begin
            tens <= 3'd0;
        end else if (!loadn) begin
            tens <= load_value;
        end else if (en) begin
            tens <= (tens == 3'd0) ? MAX_DIGIT : tens - 3'd1;
        end
    end

    assign zero = (tens == 3'd0);
    assign tc   = en & zero;

endmodule

// File: tb/tb_contador_mod_6.sv
// Self-checking bench for contador_mod_6.
// Directed steps from the test plan are followed by a randomized run against a modular-arithmetic reference.
module tb_contador_mod_6;

    logic       clk = 1'b0;
    logic       clearn;
    logic [2:0] data;
    logic       loadn;
    logic       en;
    logic [2:0] tens;
    logic       tc;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int model  = 0;

    contador_mod_6 dut (
        .clk    (clk),
        .clearn (clearn),
        .data   (data),
        .loadn  (loadn),
        .en     (en),
        .tens   (tens),
        .tc     (tc),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tens"}, tens, 3'(model));
        check({tag, ".zero"}, {2'b0, zero}, {2'b0, model == 0});
        check({tag, ".tc"}, {2'b0, tc}, {2'b0, (model == 0) && (en == 1'b1)});
    endtask

    task automatic drive(input logic c, input logic l, input logic e, input logic [2:0] d);
        clearn = c;
        loadn  = l;
        en     = e;
        data   = d;
    endtask

    // The reference model is a digit that steps down modulo 6. It sets loads with min(data, 5) and clears to 0.
    task automatic tick(input string tag);
        @(posedge clk);
        if (!clearn)
            model = 0;
        else if (!loadn)
            model = (int'(data) < 5) ? int'(data) : 5;
        else if (en)
            model = (model + 5) % 6;
        #1;
        check_all(tag);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        @(negedge clk);

        // Reset has priority over load, with en high.
        drive(1'b0, 1'b0, 1'b1, 3'd3);
        tick("reset_en1");
        en = 1'b0;
        #1;
        check_all("reset_en0");

        // Load 5, then count through a full wrap.
        drive(1'b1, 1'b0, 1'b0, 3'd5);
        tick("load5");
        drive(1'b1, 1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 7; i++) tick($sformatf("count%0d", i));

        // Hold after loading 3.
        drive(1'b1, 1'b0, 1'b0, 3'd3);
        tick("load3");
        drive(1'b1, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) tick($sformatf("hold%0d", i));

        // Priority cases.
        drive(1'b0, 1'b0, 1'b0, 3'd4);
        tick("clear_over_load");
        drive(1'b1, 1'b0, 1'b1, 3'd2);
        tick("load_over_count");

        // Illegal loads saturate.
        drive(1'b1, 1'b0, 1'b0, 3'd7);
        tick("load7");
        drive(1'b1, 1'b0, 1'b0, 3'd1);
        tick("load1");
        drive(1'b1, 1'b0, 1'b0, 3'd6);
        tick("load6");

        // At zero with en low, then raise en.
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        tick("clear_zero");
        clearn = 1'b1;
        tick("zero_hold0");
        tick("zero_hold1");
        en = 1'b1;
        #1;
        check_all("zero_en_rise");
        tick("zero_wrap");

        // Randomized run; clear and load are kept rare so counting dominates.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
            tick($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
